// File: rtl/basic_nco_core.sv
// Phase-accumulator NCO front end: modular phase integration, round-half-up quantiser.
// Optional NCO_DITHER_EN adds LFSR dither to the dropped bits before rounding.
module basic_nco_core #(
  parameter int ACC_W         = 32,
  parameter int PHASE_W       = 18,
  parameter int PHASE_POINT   = 16,
  parameter int COARSE_ADDR_W = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [ACC_W-1:0]          i_tune,
  output logic signed [PHASE_W-1:0] o_phase
);

  localparam int K = PHASE_POINT + 1;
  localparam int D = ACC_W - K;

  generate
    if ((K > PHASE_W) || (K > ACC_W) || (COARSE_ADDR_W > K)) begin : g_illegal
      $error("basic_nco_core: illegal parameter combination");
    end
  endgenerate

  // Half of the dropped-bit weight; zero when nothing is dropped
  localparam logic [ACC_W:0] WEIGHT_D = (ACC_W+1)'(1) << D;
  localparam logic [ACC_W-1:0] HALF = WEIGHT_D[ACC_W:1];

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] dith;
  logic [ACC_W-1:0] rnd;
  logic signed [K-1:0] q;

`ifdef NCO_DITHER_EN
  localparam int DW = (D < 16) ? D : 16;
  localparam logic [ACC_W:0] DMASK_F = ((ACC_W+1)'(1) << DW) - (ACC_W+1)'(1);

  logic [15:0] lfsr;
  logic        fb;

  assign fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign dith = ACC_W'(lfsr) & DMASK_F[ACC_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (ce) begin
      lfsr <= {fb, lfsr[15:1]};
    end
  end
`else
  assign dith = '0;
`endif

  assign rnd = acc + dith + HALF;
  assign q   = rnd[ACC_W-1 -: K];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      o_phase <= '0;
    end else if (ce) begin
      acc     <= acc + i_tune;
      o_phase <= PHASE_W'(q);
    end
  end

endmodule

// File: tb/tb_basic_nco_core.sv
// Self-checking bench for basic_nco_core (default build, no dither).
// Directed sequences plus randomized tuning/ce against an arithmetic phase model.
module tb_basic_nco_core;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic [31:0]        i_tune;
  logic signed [17:0] o_phase;

  int n_vec  = 0;
  int n_miss = 0;

  longint macc;
  int     exp_ph;

  basic_nco_core dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .i_tune  (i_tune),
    .o_phase (o_phase)
  );

  always #5 clk = ~clk;

  // Round-half-up to 1/2^16 half-turns, wrapped into [-1,+1)
  function automatic int q_of(input longint a);
    longint r;
    r = ((a + 64'd16384) % 64'd4294967296) / 64'd32768;
    if (r >= 64'd65536) r = r - 64'd131072;
    return int'(r);
  endfunction

  task automatic check(input string tag, input int expv);
    logic signed [17:0] e;
    e = 18'(expv);
    n_vec++;
    assert (o_phase === e) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o_phase, e);
    end
  endtask

  task automatic tick(input string tag, input bit c, input logic [31:0] t);
    ce     = c;
    i_tune = t;
    @(posedge clk);
    if (c && !reset) begin
      exp_ph = q_of(macc);
      macc   = (macc + longint'(t)) % 64'd4294967296;
    end
    #1;
    check(tag, exp_ph);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    macc   = 0;
    exp_ph = 0;
    check("reset_held", 0);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    ce     = 1'b1;
    i_tune = 32'h34000000;
    macc   = 0;
    exp_ph = 0;
    #1;
    check("reset_async", 0);

    // Reset held with ce=1, then continuous 6.5 MHz tone
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick("tone", 1'b1, 32'h34000000);

    // Stalls must hold phase
    do_reset();
    tick("stall", 1'b1, 32'h34000000);
    tick("stall", 1'b0, 32'h34000000);
    tick("stall", 1'b0, 32'h34000000);
    tick("stall", 1'b1, 32'h34000000);
    tick("stall", 1'b0, 32'h11111111);
    tick("stall", 1'b1, 32'h34000000);
    tick("stall", 1'b1, 32'h34000000);

    // Half-LSB step exercises round-half-up
    do_reset();
    for (int i = 0; i < 6; i++) tick("half_lsb", 1'b1, 32'h00004000);

    // Near half-turn step; accumulator wraps with no saturation
    do_reset();
    for (int i = 0; i < 5; i++) tick("wrap", 1'b1, 32'h7FFFC000);
    do_reset();
    for (int i = 0; i < 4; i++) tick("max", 1'b1, 32'hFFFFFFFF);

    // Short asynchronous reset pulse mid-cycle
    do_reset();
    for (int i = 0; i < 4; i++) tick("pre_pulse", 1'b1, 32'h34000000);
    #2 reset = 1'b1;
    #1;
    macc   = 0;
    exp_ph = 0;
    check("async_pulse", 0);
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) tick("post_pulse", 1'b1, 32'h34000000);

    // Randomized tuning changes and ce patterns, phase continuous
    begin
      logic [31:0] t;
      t = $urandom;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 7) == 0) t = $urandom;
        tick("random", ($urandom_range(0, 3) != 0), t);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
